// File: rtl/decode_issue_if.sv
// Bundle of the fetch-side, issue-side and writeback signals of the decode/issue stage.
//
// Handshake rules for both in_* and out_* channels: a transfer happens on a
// rising edge where valid and ready are both 1; a source holds valid and its
// payload stable until that transfer; ready may depend combinationally on the
// payload (in_ready does, through the hazard check).
interface decode_issue_if #(
    parameter int XLEN = 64,
    parameter int CNTW = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      alu_op;
    logic [1:0]      imm_type;
    logic [4:0]      rd;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic [XLEN-1:0] imm_val;
    logic            illegal;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [CNTW-1:0] stall_cnt;

    // Fetch/ALU/writeback side
    modport master (
        output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, alu_op, imm_type, rd, operand1, operand2,
               imm_val, illegal, stall_cnt
    );

    // Decode/issue stage side
    modport slave (
        input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, alu_op, imm_type, rd, operand1, operand2,
               imm_val, illegal, stall_cnt
    );
endinterface

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes fetch instructions, reads a bypassed register
// file, stalls on busy registers and issues into a single registered slot.
module decode_issue_stage #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int CNTW  = 16
) (
    input logic            clk,
    input logic            rst,
    decode_issue_if.slave  bus
);

    // Instruction fields
    logic [5:0]      f_op;
    logic [1:0]      f_type;
    logic [4:0]      f_rd;
    logic [4:0]      f_rs1;
    logic [4:0]      f_rs2;
    logic [XLEN-1:0] f_imm;

    assign f_op   = bus.in_instr[31:26];
    assign f_type = bus.in_instr[25:24];
    assign f_rd   = bus.in_instr[23:19];
    assign f_rs1  = bus.in_instr[18:14];
    assign f_rs2  = bus.in_instr[13:9];
    assign f_imm  = {{(XLEN-9){bus.in_instr[8]}}, bus.in_instr[8:0]};

    // Architectural state
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    // Issue slot
    logic            slot_valid;
    logic [5:0]      slot_op;
    logic [1:0]      slot_type;
    logic [4:0]      slot_rd;
    logic [XLEN-1:0] slot_op1;
    logic [XLEN-1:0] slot_op2;
    logic [XLEN-1:0] slot_imm;
    logic            slot_illegal;
    logic [CNTW-1:0] stall_q;

    // Decode results
    logic            legal;
    logic            use_rs2;
    logic [NREGS-1:0] wb_clr;
    logic [NREGS-1:0] busy_eff;
    logic            hazard;
    logic            ready_c;
    logic            accept;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    // Legality and source usage derived from alu_op/imm_type
    always_comb begin
        legal = 1'b0;
        case (f_type)
            2'd0:    legal = f_op inside {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd7};
            2'd1:    legal = f_op inside {6'd1, 6'd2, 6'd3, 6'd4};
            default: legal = 1'b0;
        endcase
        use_rs2 = legal && (f_type == 2'd0) && (f_op != 6'd7);
    end

    // Hazard check: a register being written back this cycle no longer counts as busy
    always_comb begin
        wb_clr = '0;
        if (bus.wb_en && bus.wb_rd != 5'd0)
            wb_clr[bus.wb_rd] = 1'b1;
        busy_eff = busy & ~wb_clr;
        hazard   = legal && (busy_eff[f_rs1] || (use_rs2 && busy_eff[f_rs2]) || busy_eff[f_rd]);
        ready_c  = !hazard && (!slot_valid || bus.out_ready);
    end

    // Operand read with same-cycle writeback bypass; r0 is hard zero
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (f_rs1 != 5'd0)
            rs1_val = (bus.wb_en && bus.wb_rd == f_rs1) ? bus.wb_data : regs[f_rs1];
        if (f_rs2 != 5'd0)
            rs2_val = (bus.wb_en && bus.wb_rd == f_rs2) ? bus.wb_data : regs[f_rs2];
    end

    assign accept       = bus.in_valid && ready_c;
    assign bus.in_ready = ready_c;

    // Issue slot: load on accept, drain when consumed, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid   <= 1'b0;
            slot_op      <= '0;
            slot_type    <= '0;
            slot_rd      <= '0;
            slot_op1     <= '0;
            slot_op2     <= '0;
            slot_imm     <= '0;
            slot_illegal <= 1'b0;
        end else if (accept) begin
            slot_valid   <= 1'b1;
            slot_op      <= legal ? f_op : 6'd0;
            slot_type    <= f_type;
            slot_rd      <= f_rd;
            slot_op1     <= legal ? rs1_val : '0;
            slot_op2     <= use_rs2 ? rs2_val : '0;
            slot_imm     <= f_imm;
            slot_illegal <= !legal;
        end else if (slot_valid && bus.out_ready) begin
            slot_valid   <= 1'b0;
        end
    end

    // Register file and busy bits; the later set overrides a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            if (bus.wb_en && bus.wb_rd != 5'd0) begin
                regs[bus.wb_rd] <= bus.wb_data;
                busy[bus.wb_rd] <= 1'b0;
            end
            if (accept && legal && f_rd != 5'd0)
                busy[f_rd] <= 1'b1;
        end
    end

    // Saturating count of cycles where fetch was blocked
    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (bus.in_valid && !ready_c && stall_q != {CNTW{1'b1}})
            stall_q <= stall_q + 1'b1;
    end

    assign bus.out_valid = slot_valid;
    assign bus.alu_op    = slot_op;
    assign bus.imm_type  = slot_type;
    assign bus.rd        = slot_rd;
    assign bus.operand1  = slot_op1;
    assign bus.operand2  = slot_op2;
    assign bus.imm_val   = slot_imm;
    assign bus.illegal   = slot_illegal;
    assign bus.stall_cnt = stall_q;

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Decode/issue stage directly upstream of the ALU.
- Accepts 32-bit instructions from fetch over a valid/ready handshake and decodes them.
- Reads operands from an internal 32x64 register file, with writeback bypass.
- Tracks pending destinations in a busy-bit scoreboard and stalls on hazards.
- Drives the ALU inputs (alu_op, operand1, operand2, imm_val, imm_type) from a registered output slot with its own valid/ready handshake.
- Accepts ALU results back through a writeback port.

Parameters:
- XLEN, 64, datapath width of registers, operands and imm_val.
- NREGS, 32, register count; r0 reads as zero.
- CNTW, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle (combinational).
- in_instr  in  32  instruction word.
- out_valid  out  1  output slot holds an issued op.
- out_ready  in  1  ALU/execute consumes the slot.
- alu_op  out  6  instr[31:26], or 0 if illegal.
- imm_type  out  2  instr[25:24]; 0 = reg-reg arith/logic, 1 = shift.
- rd  out  5  destination, instr[23:19].
- operand1  out  XLEN  value of rs1 (instr[18:14]).
- operand2  out  XLEN  value of rs2 (instr[13:9]); 0 when unused.
- imm_val  out  XLEN  instr[8:0] sign-extended.
- illegal  out  1  issued op was illegal.
- wb_en  in  1  writeback strobe.
- wb_rd  in  5  writeback register.
- wb_data  in  XLEN  writeback value.
- stall_cnt  out  CNTW  count of cycles with in_valid=1 and in_ready=0, saturating.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0; all data outputs, illegal and stall_cnt cleared to 0.
  - All busy bits and all registers cleared to 0.
  - Reset mid-operation discards the slot contents and the scoreboard.
- Legality:
  - imm_type 0: alu_op must be in {1,2,3,4,5,7}.
  - imm_type 1: alu_op must be in {1,2,3,4}.
  - imm_type 2 or 3: always illegal.
- Source usage:
  - rs1 is used by every legal op.
  - rs2 is used only for imm_type 0 with alu_op != 7 (NOT).
  - Unused sources are never hazard-checked; operand2 is driven 0 when rs2 is unused.
- Hazard, evaluated combinationally on in_instr:
  - A hazard exists if any used source, or rd, is nonzero and busy.
  - A busy bit cleared by a same-cycle wb_en to that register does not count.
  - Illegal instructions never hazard.
- Handshake:
  - in_ready = !hazard && (!out_valid || out_ready).
  - An accept occurs when in_valid && in_ready.
  - On an accept, the slot loads next edge and out_valid=1. Latency is 1 cycle, and the stage sustains 1 instr/cycle without hazards.
  - If out_valid && out_ready and there is no accept, out_valid goes to 0 next edge.
  - If out_valid && !out_ready, all slot outputs hold stable.
- Operand read:
  - r0 reads as 0.
  - If wb_en && wb_rd == src && src != 0, the operand takes wb_data (same-cycle bypass); otherwise it takes the register file value.
- Writeback:
  - wb_en writes wb_data to wb_rd and clears busy[wb_rd].
  - Writes to r0 are ignored.
- Scoreboard:
  - An accepted legal op with rd != 0 sets busy[rd].
  - If set and clear hit the same register in the same cycle, set wins.
  - An illegal op sets nothing, issues with alu_op=0 and illegal=1, and still occupies the slot.
- stall_cnt increments each cycle with in_valid && !in_ready and saturates at all ones.

Test Plan:
- Back-to-back issue: r1=5, r2=3 preloaded via wb. Issue ADD r3,r1,r2 then ADD r4,r1,r2 with out_ready=1 -> out_valid on consecutive cycles, operand1=5, operand2=3, alu_op=1, stall_cnt=0.
- RAW stall: ADD r3,r1,r2 followed by SUB r5,r3,r1 -> in_ready=0 until wb_en with wb_rd=3. In the wb cycle the SUB is accepted with operand1=wb_data (bypass). stall_cnt equals the number of stalled cycles.
- Shift immediate and sign-extension: imm_type 1, alu_op=1, imm9=0x1FF -> imm_val=0xFFFF_FFFF_FFFF_FFFF and operand2=0. NOT r6,r1 -> rs2 busy does not stall.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0. Raise out_ready -> a new instruction is accepted in the same cycle.
- Illegal plus r0: imm_type 2 -> illegal=1, alu_op=0, no busy bit set. wb_en to r0 with 0xDEAD, then reading r0 -> 0.
- Reset mid-stall: rst while a RAW stall is active -> next cycle out_valid=0, busy cleared, and the stalled instruction is accepted immediately.
